// File: rtl/max_pooling_stream.sv
// Streaming 2x2 / stride-2 max-pool with a half-row line buffer and valid/ready on both sides.
// Optional fused ReLU on the output load when MAXPOOL_RELU_EN is defined.
module max_pooling_stream #(
   parameter int unsigned DATA_BITS = 32,
   parameter int unsigned CH        = 4,
   parameter int unsigned H         = 46,
   parameter int unsigned W         = 46,
   parameter int unsigned SIGNED    = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [CH*DATA_BITS-1:0] in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [CH*DATA_BITS-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    frame_done
);

   localparam int unsigned DW       = CH * DATA_BITS;
   localparam int unsigned CW       = $clog2(W);
   localparam int unsigned RW       = $clog2(H);
   localparam int unsigned LB_DEPTH = W / 2;
   localparam int unsigned LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam int unsigned W_EVEN   = 2 * (W / 2);
   localparam int unsigned H_EVEN   = 2 * (H / 2);
   // Flipping the MSB maps two's-complement order onto unsigned order.
   localparam logic [DATA_BITS-1:0] SIGN_FLIP =
      (SIGNED != 0) ? {1'b1, {(DATA_BITS-1){1'b0}}} : '0;

   function automatic logic [DW-1:0] vmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0]        r;
      logic [DATA_BITS-1:0] ak;
      logic [DATA_BITS-1:0] bk;
      r = '0;
      for (int unsigned k = 0; k < CH; k++) begin
         ak = a[k*DATA_BITS +: DATA_BITS];
         bk = b[k*DATA_BITS +: DATA_BITS];
         r[k*DATA_BITS +: DATA_BITS] = ((ak ^ SIGN_FLIP) >= (bk ^ SIGN_FLIP)) ? ak : bk;
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] out_fmt(input logic [DW-1:0] v);
      logic [DW-1:0] r;
      r = v;
`ifdef MAXPOOL_RELU_EN
      for (int unsigned k = 0; k < CH; k++) begin
         if ((SIGNED != 0) && v[k*DATA_BITS + DATA_BITS - 1]) begin
            r[k*DATA_BITS +: DATA_BITS] = '0;
         end
      end
`endif
      return r;
   endfunction

   logic [CW-1:0]  col_q, col_d;
   logic [RW-1:0]  row_q, row_d;
   logic [DW-1:0]  hold_q, hold_d;
   logic [DW-1:0]  out_data_q, out_data_d;
   logic           out_valid_q, out_valid_d;
   logic           out_last_q, out_last_d;
   logic           frame_done_q, frame_done_d;

   logic [DW-1:0]  lb_q [LB_DEPTH];
   logic           lb_we_c;
   logic [LBW-1:0] lb_idx_c;
   logic [DW-1:0]  lb_wdata_c;

   logic accept_c;
   logic pop_c;
   logic in_win_c;
   logic last_col_c;
   logic last_row_c;

   assign in_ready   = !out_valid_q || out_ready;
   assign accept_c   = in_valid && in_ready;
   assign pop_c      = out_valid_q && out_ready;
   assign in_win_c   = (32'(col_q) < W_EVEN) && (32'(row_q) < H_EVEN);
   assign last_col_c = (col_q == CW'(W - 1));
   assign last_row_c = (row_q == RW'(H - 1));

   // Position counters, pooling datapath and output handshake.
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      hold_d       = hold_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      frame_done_d = 1'b0;
      lb_we_c      = 1'b0;
      lb_idx_c     = LBW'(col_q >> 1);
      lb_wdata_c   = vmax(hold_q, in_data);

      if (pop_c) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      if (accept_c) begin
         if (last_col_c) begin
            col_d        = '0;
            row_d        = last_row_c ? '0 : row_q + RW'(1);
            frame_done_d = last_row_c;
         end else begin
            col_d = col_q + CW'(1);
         end

         if (in_win_c) begin
            unique case ({row_q[0], col_q[0]})
               2'b00: hold_d  = in_data;
               2'b01: lb_we_c = 1'b1;
               2'b10: hold_d  = vmax(lb_q[lb_idx_c], in_data);
               2'b11: begin
                  out_data_d  = out_fmt(vmax(hold_q, in_data));
                  out_valid_d = 1'b1;
                  out_last_d  = (row_q == RW'(H_EVEN - 1)) && (col_q == CW'(W_EVEN - 1));
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q        <= '0;
         row_q        <= '0;
         hold_q       <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         hold_q       <= hold_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line buffer holds even-row pair maxima; always written before the odd row reads it.
   always_ff @(posedge clk) begin
      if (lb_we_c) begin
         lb_q[lb_idx_c] <= lb_wdata_c;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign frame_done = frame_done_q;

endmodule
